// File: rtl/phy_tx_serializer.sv
// Two-lane transmit serializer: whole 32-bit words alternate between lanes, 4 bytes per word, MSB first.
// A SYNC preamble follows reset; lanes with nothing buffered send IDLE bytes.
module phy_tx_serializer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hBC,
    parameter logic [7:0]  IDLE_BYTE = 8'hBC,
    parameter int unsigned N_SYNC    = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        output_0,
    output logic        output_1,
    output logic        active_out,
    output logic        wr_lane
);

    typedef enum logic {SYNC, ACTIVE} state_t;

    typedef struct packed {
        logic [7:0] sh;
        logic [1:0] idx;
        logic       full;
    } lane_t;

    localparam logic [3:0] SYNC_LAST = 4'(N_SYNC - 1);

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [3:0]  sync_cnt;
    lane_t       lane0;
    lane_t       lane1;
    logic [31:0] word_buf [2];
    logic        boundary;
    logic        accept;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    pick_byte = w[31:24];
            2'd1:    pick_byte = w[23:16];
            2'd2:    pick_byte = w[15:8];
            default: pick_byte = w[7:0];
        endcase
    endfunction

    // Next value of one lane; a full buffer always drains on consecutive byte slots.
    function automatic lane_t lane_step(input lane_t cur, input logic at_boundary,
                                        input logic is_active, input logic [31:0] w);
        lane_t nxt;
        nxt = cur;
        if (!at_boundary) begin
            nxt.sh = {cur.sh[6:0], 1'b0};
        end else if (!is_active) begin
            nxt.sh = SYNC_BYTE;
        end else if (cur.full) begin
            nxt.sh = pick_byte(w, cur.idx);
            if (cur.idx == 2'd3) begin
                nxt.full = 1'b0;
                nxt.idx  = 2'd0;
            end else begin
                nxt.idx = cur.idx + 2'd1;
            end
        end else begin
            nxt.sh = IDLE_BYTE;
        end
        return nxt;
    endfunction

    assign boundary  = (bit_cnt == 3'd7);
    assign ready_out = (state == ACTIVE) && !(wr_lane ? lane1.full : lane0.full);
    assign accept    = valid_in && ready_out;
    assign output_0  = lane0.sh[7];
    assign output_1  = lane1.sh[7];

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state      <= SYNC;
            active_out <= 1'b0;
            bit_cnt    <= 3'd7;
            sync_cnt   <= 4'd0;
            wr_lane    <= 1'b0;
            lane0      <= '0;
            lane1      <= '0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            lane0   <= lane_step(lane0, boundary, state == ACTIVE, word_buf[0]);
            lane1   <= lane_step(lane1, boundary, state == ACTIVE, word_buf[1]);

            if (boundary && state == SYNC) begin
                sync_cnt <= sync_cnt + 4'd1;
                if (sync_cnt == SYNC_LAST) begin
                    state      <= ACTIVE;
                    active_out <= 1'b1;
                end
            end

            // A lane only accepts while empty, so this never collides with its own byte load.
            if (accept) begin
                if (wr_lane) begin
                    lane1.full <= 1'b1;
                    lane1.idx  <= 2'd0;
                end else begin
                    lane0.full <= 1'b1;
                    lane0.idx  <= 2'd0;
                end
                wr_lane <= ~wr_lane;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (accept) begin
            word_buf[wr_lane] <= data_in;
        end
    end

endmodule
